vid_timing_gen: RTL and testbench

//  Parametrised, run-time-configurable video timing + test-pattern source. Generates line/frame

---
 rtl/vid_timing_gen.sv | 246 ++++++++++++++++++++++++
 tb/tb_vid_timing_gen.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vid_timing_gen.sv
// Video timing and test-pattern source. A run-time configurable raster
// (blanking + active region) is swept by h/v counters; every output is a
// register decoded from the counters' next values, so no input reaches an
// output combinationally. New configuration only takes effect at a start or
// at a frame boundary, so a frame is never torn by a mid-frame update.
//
// Handshake note: this block has no valid/ready pairs. lval/fval qualify
// pix_x/pix_y/pix_data on every cycle where en=1; en=0 freezes everything,
// so a downstream sink must qualify with en as well.
module vid_timing_gen #(
  parameter int CNT_W    = 12,
  parameter int PIX_W    = 12,
  parameter int FCNT_W   = 16,
  parameter int CHK_SH   = 3,
  parameter int DEF_HACT = 1920,
  parameter int DEF_HBP  = 50,
  parameter int DEF_HFP  = 50,
  parameter int DEF_VACT = 1080,
  parameter int DEF_VBP  = 5,
  parameter int DEF_VFP  = 5
) (
  input  logic              pixclk,
  input  logic              rst,
  input  logic              en,
  input  logic              start,
  input  logic              stop,
  input  logic              single,
  input  logic [1:0]        pat_mode,
  input  logic [CNT_W-1:0]  cfg_hact,
  input  logic [CNT_W-1:0]  cfg_hbp,
  input  logic [CNT_W-1:0]  cfg_hfp,
  input  logic [CNT_W-1:0]  cfg_vact,
  input  logic [CNT_W-1:0]  cfg_vbp,
  input  logic [CNT_W-1:0]  cfg_vfp,
  output logic              lval,
  output logic              fval,
  output logic              sof,
  output logic              eol,
  output logic              eof,
  output logic [CNT_W-1:0]  pix_x,
  output logic [CNT_W-1:0]  pix_y,
  output logic [PIX_W-1:0]  pix_data,
  output logic [FCNT_W-1:0] frm_cnt,
  output logic              busy,
  output logic              cfg_err,
  output logic              state_dbg
);

  // Totals need two extra bits: three CNT_W-wide terms can reach 3*(2**CNT_W - 1).
  localparam int SW = CNT_W + 2;
  localparam logic [SW-1:0] CNT_LIM = SW'(1) << CNT_W;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]  hcnt, vcnt, hcnt_n, vcnt_n;
  logic [CNT_W-1:0]  sh_hact, sh_hbp, sh_hfp, sh_vact, sh_vbp, sh_vfp;
  logic [CNT_W-1:0]  sh_hact_n, sh_hbp_n, sh_hfp_n, sh_vact_n, sh_vbp_n, sh_vfp_n;
  logic [1:0]        sh_pat, sh_pat_n;
  logic              sh_single, sh_single_n;
  logic              stop_pend, stop_pend_n;
  logic [FCNT_W-1:0] frm_cnt_n;
  logic              cfg_err_n;

  logic              lval_n, fval_n, sof_n, eol_n, eof_n, busy_n;
  logic [CNT_W-1:0]  pix_x_n, pix_y_n;
  logic [PIX_W-1:0]  pix_data_n;

  logic [SW-1:0]     ht, vt, in_ht, in_vt;
  logic              cfg_ok_in, h_last, v_last, frame_end, end_run;

  function automatic logic [SW-1:0] ext(input logic [CNT_W-1:0] v);
    return {2'b00, v};
  endfunction

  assign ht        = ext(sh_hbp) + ext(sh_hact) + ext(sh_hfp);
  assign vt        = ext(sh_vbp) + ext(sh_vact) + ext(sh_vfp);
  assign in_ht     = ext(cfg_hbp) + ext(cfg_hact) + ext(cfg_hfp);
  assign in_vt     = ext(cfg_vbp) + ext(cfg_vact) + ext(cfg_vfp);
  assign cfg_ok_in = (cfg_hact != '0) && (cfg_vact != '0) &&
                     (in_ht <= CNT_LIM) && (in_vt <= CNT_LIM);
  assign h_last    = (ext(hcnt) == ht - SW'(1));
  assign v_last    = (ext(vcnt) == vt - SW'(1));
  assign frame_end = (state == S_RUN) && h_last && v_last;
  // A stop arriving on the frame-end cycle still ends this frame.
  assign end_run   = sh_single | stop_pend | stop;
  assign state_dbg = (state == S_RUN);

  // State register; en=0 freezes the FSM.
  always_ff @(posedge pixclk or posedge rst) begin
    if (rst)     state <= S_IDLE;
    else if (en) state <= state_nxt;
  end

  // Next-state: accept a start only with a legal config; leave RUN at frame end when asked.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start && cfg_ok_in) state_nxt = S_RUN;
      S_RUN:   if (frame_end && end_run) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Next counters, shadow config, frame count and error flag.
  always_comb begin
    hcnt_n      = hcnt;
    vcnt_n      = vcnt;
    sh_hact_n   = sh_hact;
    sh_hbp_n    = sh_hbp;
    sh_hfp_n    = sh_hfp;
    sh_vact_n   = sh_vact;
    sh_vbp_n    = sh_vbp;
    sh_vfp_n    = sh_vfp;
    sh_pat_n    = sh_pat;
    sh_single_n = sh_single;
    stop_pend_n = stop_pend;
    frm_cnt_n   = frm_cnt;
    cfg_err_n   = cfg_err;
    case (state)
      S_IDLE: begin
        hcnt_n = '0;
        vcnt_n = '0;
        if (start) begin
          if (cfg_ok_in) begin
            sh_hact_n   = cfg_hact;
            sh_hbp_n    = cfg_hbp;
            sh_hfp_n    = cfg_hfp;
            sh_vact_n   = cfg_vact;
            sh_vbp_n    = cfg_vbp;
            sh_vfp_n    = cfg_vfp;
            sh_pat_n    = pat_mode;
            sh_single_n = single;
            cfg_err_n   = 1'b0;
            stop_pend_n = 1'b0;
          end else begin
            cfg_err_n = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (stop) stop_pend_n = 1'b1;
        if (frame_end) begin
          hcnt_n    = '0;
          vcnt_n    = '0;
          frm_cnt_n = frm_cnt + FCNT_W'(1);
          if (end_run) begin
            stop_pend_n = 1'b0;
          end else if (cfg_ok_in) begin
            sh_hact_n = cfg_hact;
            sh_hbp_n  = cfg_hbp;
            sh_hfp_n  = cfg_hfp;
            sh_vact_n = cfg_vact;
            sh_vbp_n  = cfg_vbp;
            sh_vfp_n  = cfg_vfp;
            sh_pat_n  = pat_mode;
          end else begin
            cfg_err_n = 1'b1;
          end
        end else if (h_last) begin
          hcnt_n = '0;
          vcnt_n = vcnt + CNT_W'(1);
        end else begin
          hcnt_n = hcnt + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Output decode from the next counter/shadow values so outputs line up with the counters.
  always_comb begin
    busy_n     = (state_nxt == S_RUN);
    fval_n     = busy_n && (ext(vcnt_n) >= ext(sh_vbp_n)) &&
                 (ext(vcnt_n) < ext(sh_vbp_n) + ext(sh_vact_n));
    lval_n     = fval_n && (ext(hcnt_n) >= ext(sh_hbp_n)) &&
                 (ext(hcnt_n) < ext(sh_hbp_n) + ext(sh_hact_n));
    pix_x_n    = lval_n ? hcnt_n - sh_hbp_n : '0;
    pix_y_n    = lval_n ? vcnt_n - sh_vbp_n : '0;
    sof_n      = lval_n && (pix_x_n == '0) && (pix_y_n == '0);
    eol_n      = lval_n && (pix_x_n == sh_hact_n - CNT_W'(1));
    eof_n      = eol_n && (pix_y_n == sh_vact_n - CNT_W'(1));
    pix_data_n = '0;
    if (lval_n) begin
      case (sh_pat_n)
        2'd1:    pix_data_n = PIX_W'(pix_x_n);
        2'd2:    pix_data_n = PIX_W'(pix_y_n);
        2'd3:    pix_data_n = {PIX_W{pix_x_n[CHK_SH] ^ pix_y_n[CHK_SH] ^ frm_cnt_n[0]}};
        default: pix_data_n = '0;
      endcase
    end
  end

  // Datapath and output registers; en=0 holds every one of them, strobes included.
  always_ff @(posedge pixclk or posedge rst) begin
    if (rst) begin
      hcnt      <= '0;
      vcnt      <= '0;
      sh_hact   <= CNT_W'(DEF_HACT);
      sh_hbp    <= CNT_W'(DEF_HBP);
      sh_hfp    <= CNT_W'(DEF_HFP);
      sh_vact   <= CNT_W'(DEF_VACT);
      sh_vbp    <= CNT_W'(DEF_VBP);
      sh_vfp    <= CNT_W'(DEF_VFP);
      sh_pat    <= 2'd0;
      sh_single <= 1'b0;
      stop_pend <= 1'b0;
      frm_cnt   <= '0;
      cfg_err   <= 1'b0;
      lval      <= 1'b0;
      fval      <= 1'b0;
      sof       <= 1'b0;
      eol       <= 1'b0;
      eof       <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_data  <= '0;
      busy      <= 1'b0;
    end else if (en) begin
      hcnt      <= hcnt_n;
      vcnt      <= vcnt_n;
      sh_hact   <= sh_hact_n;
      sh_hbp    <= sh_hbp_n;
      sh_hfp    <= sh_hfp_n;
      sh_vact   <= sh_vact_n;
      sh_vbp    <= sh_vbp_n;
      sh_vfp    <= sh_vfp_n;
      sh_pat    <= sh_pat_n;
      sh_single <= sh_single_n;
      stop_pend <= stop_pend_n;
      frm_cnt   <= frm_cnt_n;
      cfg_err   <= cfg_err_n;
      lval      <= lval_n;
      fval      <= fval_n;
      sof       <= sof_n;
      eol       <= eol_n;
      eof       <= eof_n;
      pix_x     <= pix_x_n;
      pix_y     <= pix_y_n;
      pix_data  <= pix_data_n;
      busy      <= busy_n;
    end
  end

endmodule

// File: tb/tb_vid_timing_gen.sv
// Bench for vid_timing_gen: a frame-position reference model (linear pixel
// index within the frame, split into line/column arithmetically) predicts
// every output each cycle; scenario tasks add count and latency checks.
module tb_vid_timing_gen;
  localparam int CW = 12;
  localparam int VW = 5 + 3 * 12 + 16 + 2;

  logic pixclk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0, start = 1'b0, stop = 1'b0, single = 1'b0;
  logic [1:0] pat_mode = 2'd0;
  logic [CW-1:0] cfg_hact = '0, cfg_hbp = '0, cfg_hfp = '0;
  logic [CW-1:0] cfg_vact = '0, cfg_vbp = '0, cfg_vfp = '0;
  logic lval, fval, sof, eol, eof, busy, cfg_err, state_dbg;
  logic [CW-1:0] pix_x, pix_y;
  logic [11:0] pix_data;
  logic [15:0] frm_cnt;

  logic [VW-1:0] dut_vec, exp_vec;
  int checks = 0;
  int errors = 0;

  // model state
  int m_run, m_p, m_frm, m_err, m_pend, m_single;
  int c_hact, c_hbp, c_hfp, c_vact, c_vbp, c_vfp, c_pat;

  vid_timing_gen dut (
    .pixclk(pixclk), .rst(rst), .en(en), .start(start), .stop(stop), .single(single),
    .pat_mode(pat_mode), .cfg_hact(cfg_hact), .cfg_hbp(cfg_hbp), .cfg_hfp(cfg_hfp),
    .cfg_vact(cfg_vact), .cfg_vbp(cfg_vbp), .cfg_vfp(cfg_vfp),
    .lval(lval), .fval(fval), .sof(sof), .eol(eol), .eof(eof),
    .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data), .frm_cnt(frm_cnt),
    .busy(busy), .cfg_err(cfg_err), .state_dbg(state_dbg)
  );

  assign dut_vec = {lval, fval, sof, eol, eof, pix_x, pix_y, pix_data, frm_cnt, busy, cfg_err};

  // clock
  always #5 pixclk = ~pixclk;

  // ---------------- reference model ----------------
  function automatic int in_ok();
    return (cfg_hact != 0) && (cfg_vact != 0) &&
           ((int'(cfg_hbp) + int'(cfg_hact) + int'(cfg_hfp)) <= 4096) &&
           ((int'(cfg_vbp) + int'(cfg_vact) + int'(cfg_vfp)) <= 4096);
  endfunction

  task automatic model_load();
    c_hact = int'(cfg_hact); c_hbp = int'(cfg_hbp); c_hfp = int'(cfg_hfp);
    c_vact = int'(cfg_vact); c_vbp = int'(cfg_vbp); c_vfp = int'(cfg_vfp);
    c_pat  = int'(pat_mode);
  endtask

  task automatic model_out();
    int ht, h, v, lv, fv, so, eo, ef, x, y, d;
    lv = 0; fv = 0; so = 0; eo = 0; ef = 0; x = 0; y = 0; d = 0;
    if (m_run != 0) begin
      ht = c_hbp + c_hact + c_hfp;
      h = m_p % ht;
      v = m_p / ht;
      fv = (v >= c_vbp) && (v < c_vbp + c_vact);
      lv = fv && (h >= c_hbp) && (h < c_hbp + c_hact);
      if (lv != 0) begin
        x = h - c_hbp;
        y = v - c_vbp;
        so = (x == 0) && (y == 0);
        eo = (x == c_hact - 1);
        ef = eo && (y == c_vact - 1);
        case (c_pat)
          1: d = x;
          2: d = y;
          3: d = ((((x >> 3) ^ (y >> 3) ^ m_frm) & 1) != 0) ? 12'hfff : 0;
          default: d = 0;
        endcase
      end
    end
    exp_vec = {1'(lv), 1'(fv), 1'(so), 1'(eo), 1'(ef), 12'(x), 12'(y), 12'(d),
               16'(m_frm), 1'(m_run), 1'(m_err)};
  endtask

  task automatic model_reset();
    m_run = 0; m_p = 0; m_frm = 0; m_err = 0; m_pend = 0; m_single = 0;
    c_hact = 1920; c_hbp = 50; c_hfp = 50; c_vact = 1080; c_vbp = 5; c_vfp = 5; c_pat = 0;
    model_out();
  endtask

  // advance the model by one clock edge using the inputs that edge sampled
  task automatic model_step();
    int fl;
    if (en) begin
      if (m_run == 0) begin
        if (start) begin
          if (in_ok() != 0) begin
            model_load();
            m_single = int'(single);
            m_run = 1; m_err = 0; m_pend = 0; m_p = 0;
          end else begin
            m_err = 1;
          end
        end
      end else begin
        fl = (c_hbp + c_hact + c_hfp) * (c_vbp + c_vact + c_vfp);
        if (stop) m_pend = 1;
        if (m_p == fl - 1) begin
          m_frm = (m_frm + 1) & 16'hffff;
          m_p = 0;
          if (m_pend != 0 || m_single != 0) begin
            m_run = 0; m_pend = 0;
          end else if (in_ok() != 0) begin
            model_load();
          end else begin
            m_err = 1;
          end
        end else begin
          m_p = m_p + 1;
        end
      end
    end
    model_out();
  endtask

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge pixclk);
    #1;
    model_step();
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    en = 1'b0; start = 1'b0; stop = 1'b0; single = 1'b0;
    model_reset();
    #3 rst = 1'b0;
  endtask

  task automatic set_spec_cfg();
    cfg_hact = 12'd8; cfg_hbp = 12'd2; cfg_hfp = 12'd2;
    cfg_vact = 12'd4; cfg_vbp = 12'd1; cfg_vfp = 12'd1;
  endtask

  task automatic rand_cfg();
    cfg_hact = 12'($urandom_range(0, 12));
    cfg_hbp  = 12'($urandom_range(0, 3));
    cfg_hfp  = 12'($urandom_range(0, 3));
    cfg_vact = 12'($urandom_range(1, 6));
    cfg_vbp  = 12'($urandom_range(0, 2));
    cfg_vfp  = 12'($urandom_range(0, 2));
    pat_mode = 2'($urandom_range(0, 3));
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    #1;
    if (dut_vec !== exp_vec) begin
      errors++; $display("FAIL reset_outputs: got %h exp %h", dut_vec, exp_vec);
    end
    checks++;
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (dut_vec !== exp_vec) begin
        errors++; $display("FAIL reset_idle cyc %0d: got %h exp %h", i, dut_vec, exp_vec);
      end
      checks++;
    end
  endtask

  task automatic test_spec_frame();
    int nl, ns, ne, nf, fall;
    do_reset();
    set_spec_cfg(); pat_mode = 2'd1; single = 1'b0; en = 1'b1; start = 1'b1;
    nl = 0; ns = 0; ne = 0; nf = 0;
    for (int i = 0; i < 82; i++) begin
      tick();
      start = 1'b0;
      if (dut_vec !== exp_vec) begin
        errors++; $display("FAIL spec_frame cyc %0d: got %h exp %h", i, dut_vec, exp_vec);
      end
      checks++;
      if (i < 72) begin nl += int'(lval); ns += int'(sof); ne += int'(eol); nf += int'(eof); end
    end
    if (nl != 32) begin errors++; $display("FAIL spec_lval_count: got %0d exp 32", nl); end
    checks++;
    if (ns != 1 || nf != 1 || ne != 4) begin
      errors++; $display("FAIL spec_strobe_count: sof %0d eol %0d eof %0d exp 1 4 1", ns, ne, nf);
    end
    checks++;
    stop = 1'b1;
    fall = -1;
    for (int i = 0; i < 100 && fall < 0; i++) begin
      tick();
      stop = 1'b0;
      if (dut_vec !== exp_vec) begin
        errors++; $display("FAIL spec_stop cyc %0d: got %h exp %h", i, dut_vec, exp_vec);
      end
      checks++;
      if (busy === 1'b0) fall = i;
    end
    if (fall < 0 || frm_cnt !== 16'd2) begin
      errors++; $display("FAIL spec_stop_end: fall %0d frm %0d exp frm 2", fall, frm_cnt);
    end
    checks++;
  endtask

  task automatic test_single_and_stop();
    int fall;
    for (int mode = 0; mode < 2; mode++) begin
      do_reset();
      set_spec_cfg(); pat_mode = 2'd2; en = 1'b1; start = 1'b1;
      single = (mode == 0);
      fall = -1;
      for (int i = 0; i < 200 && fall < 0; i++) begin
        tick();
        start = 1'b0;
        single = 1'b0;
        stop = (mode == 1 && i == 29);
        if (dut_vec !== exp_vec) begin
          errors++; $display("FAIL single_stop m%0d cyc %0d: got %h exp %h", mode, i, dut_vec, exp_vec);
        end
        checks++;
        if (busy === 1'b0) fall = i;
      end
      stop = 1'b0;
      if (fall != 72 || frm_cnt !== 16'd1) begin
        errors++; $display("FAIL single_stop_end m%0d: fall %0d frm %0d exp 72 1", mode, fall, frm_cnt);
      end
      checks++;
    end
  endtask

  task automatic test_cfg_change();
    int n1, n2;
    do_reset();
    set_spec_cfg(); pat_mode = 2'd1; single = 1'b0; en = 1'b1; start = 1'b1;
    n1 = 0; n2 = 0;
    for (int i = 0; i < 120; i++) begin
      tick();
      start = 1'b0;
      if (i == 20) cfg_hact = 12'd4;
      if (dut_vec !== exp_vec) begin
        errors++; $display("FAIL cfg_change cyc %0d: got %h exp %h", i, dut_vec, exp_vec);
      end
      checks++;
      if (i < 72) n1 += int'(lval); else n2 += int'(lval);
    end
    if (n1 != 32 || n2 != 16) begin
      errors++; $display("FAIL cfg_change_lval: got %0d/%0d exp 32/16", n1, n2);
    end
    checks++;
  endtask

  task automatic test_cfg_err();
    do_reset();
    set_spec_cfg(); cfg_hact = 12'd0; en = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    if (cfg_err !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL cfg_err_zero: err %b busy %b exp 1 0", cfg_err, busy);
    end
    checks++;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (dut_vec !== exp_vec) begin
        errors++; $display("FAIL cfg_err_hold cyc %0d: got %h exp %h", i, dut_vec, exp_vec);
      end
      checks++;
    end
    cfg_hact = 12'd4000; cfg_hbp = 12'd50; cfg_hfp = 12'd50; start = 1'b1;
    tick();
    start = 1'b0;
    if (dut_vec !== exp_vec || busy !== 1'b0) begin
      errors++; $display("FAIL cfg_err_oversize: got %h exp %h", dut_vec, exp_vec);
    end
    checks++;
    set_spec_cfg(); start = 1'b1;
    tick();
    start = 1'b0;
    if (cfg_err !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL cfg_err_clear: err %b busy %b exp 0 1", cfg_err, busy);
    end
    checks++;
  endtask

  task automatic test_enable();
    int got;
    do_reset();
    set_spec_cfg(); pat_mode = 2'd3; en = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    got = -1;
    for (int i = 1; i < 200 && got < 0; i++) begin
      en = !(i >= 15 && i < 20);
      tick();
      if (dut_vec !== exp_vec) begin
        errors++; $display("FAIL enable cyc %0d: got %h exp %h", i, dut_vec, exp_vec);
      end
      checks++;
      if (frm_cnt === 16'd1) got = i;
    end
    en = 1'b1;
    if (got != 77) begin errors++; $display("FAIL enable_frame_len: got %0d exp 77", got); end
    checks++;
  endtask

  task automatic test_rst_mid();
    do_reset();
    set_spec_cfg(); pat_mode = 2'd1; en = 1'b1; start = 1'b1;
    for (int i = 0; i < 40; i++) begin tick(); start = 1'b0; end
    #2 rst = 1'b1;
    model_reset();
    #1;
    if (dut_vec !== {VW{1'b0}} || state_dbg !== 1'b0) begin
      errors++; $display("FAIL rst_mid_async: got %h exp 0", dut_vec);
    end
    checks++;
    #2 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (dut_vec !== exp_vec) begin
        errors++; $display("FAIL rst_mid_after cyc %0d: got %h exp %h", i, dut_vec, exp_vec);
      end
      checks++;
    end
  endtask

  task automatic test_boundary();
    int fall, ne, nf;
    do_reset();
    cfg_hact = 12'd4000; cfg_hbp = 12'd48; cfg_hfp = 12'd48;
    cfg_vact = 12'd1; cfg_vbp = 12'd0; cfg_vfp = 12'd0;
    pat_mode = 2'd1; single = 1'b1; en = 1'b1; start = 1'b1;
    fall = -1; ne = 0; nf = 0;
    for (int i = 0; i < 4300 && fall < 0; i++) begin
      tick();
      start = 1'b0; single = 1'b0;
      if (dut_vec !== exp_vec) begin
        errors++; $display("FAIL boundary cyc %0d: got %h exp %h", i, dut_vec, exp_vec);
      end
      checks++;
      ne += int'(eol); nf += int'(eof);
      if (busy === 1'b0) fall = i;
    end
    if (fall != 4096 || ne != 1 || nf != 1) begin
      errors++; $display("FAIL boundary_frame: fall %0d eol %0d eof %0d exp 4096 1 1", fall, ne, nf);
    end
    checks++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      do_reset();
      rand_cfg();
      single = ($urandom_range(0, 3) == 0);
      en = 1'b1; start = 1'b1;
      for (int c = 0; c < 300; c++) begin
        tick();
        en     = ($urandom_range(0, 9) != 0);
        stop   = ($urandom_range(0, 99) == 0);
        start  = ($urandom_range(0, 49) == 0);
        single = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 29) == 0) rand_cfg();
        if (dut_vec !== exp_vec) begin
          errors++; $display("FAIL random it%0d cyc %0d: got %h exp %h", it, c, dut_vec, exp_vec);
        end
        checks++;
      end
      start = 1'b0; stop = 1'b0;
    end
  endtask

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_spec_frame();
    test_single_and_stop();
    test_cfg_change();
    test_cfg_err();
    test_enable();
    test_rst_mid();
    test_boundary();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
